// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Operands handed to the ALU are forwarded combinationally from the latched
// register-file data, so a result arriving from MEM or WB is seen in the same cycle.
module id_exe_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic              id_b_sel,
  input  logic [3:0]        id_alu_oper,
  input  logic              id_wb_en,
  input  logic [ADDR_W-1:0] id_wb_addr,
  input  logic              id_mem_ren,
  input  logic              id_mem_wen,
  input  logic              mem_wb_en,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wb_en,
  input  logic [ADDR_W-1:0] wb_wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              load_use_stall,
  output logic              exe_valid,
  output logic [31:0]       exe_pc,
  output logic [DATA_W-1:0] exe_alu_a,
  output logic [DATA_W-1:0] exe_alu_b,
  output logic [3:0]        exe_alu_oper,
  output logic [DATA_W-1:0] exe_rt_fwd,
  output logic              exe_wb_en,
  output logic [ADDR_W-1:0] exe_wb_addr,
  output logic              exe_mem_ren,
  output logic              exe_mem_wen
);

  // ALU operation code for addition; a bubble carries this harmless op.
  localparam logic [3:0] EXE_ALU_ADD = 4'b0010;

  logic              valid_q,   valid_d;
  logic [31:0]       pc_q,      pc_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              b_sel_q,   b_sel_d;
  logic [3:0]        oper_q,    oper_d;
  logic              wb_en_q,   wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // Register $0 never forwards; MEM is younger than WB so it wins.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] latched,
    input logic              m_en,
    input logic [ADDR_W-1:0] m_addr,
    input logic [DATA_W-1:0] m_data,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] res;
    res = latched;
    if (src != '0) begin
      if (m_en && (m_addr == src))      res = m_data;
      else if (w_en && (w_addr == src)) res = w_data;
    end
    return res;
  endfunction

  // Same-cycle operand forwarding for both sources.
  always_comb begin
    rs_fwd = fwd_sel(rs_addr_q, rs_data_q, mem_wb_en, mem_wb_addr, mem_data,
                     wb_wb_en, wb_wb_addr, wb_data);
    rt_fwd = fwd_sel(rt_addr_q, rt_data_q, mem_wb_en, mem_wb_addr, mem_data,
                     wb_wb_en, wb_wb_addr, wb_data);
  end

  // A load in EXE whose destination is read by the instruction in ID.
  always_comb begin
    load_use_stall = valid_q && mem_ren_q && wb_en_q && (wb_addr_q != '0) && id_valid &&
                     ((wb_addr_q == id_rs_addr) || (wb_addr_q == id_rt_addr));
  end

  // Next-state: flush beats hold, hold beats stall bubble, else capture ID.
  always_comb begin
    // Hold, with operand data refreshed so a forwarded value survives the stall.
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_data_d = rs_fwd;
    rt_data_d = rt_fwd;
    imm_d     = imm_q;
    b_sel_d   = b_sel_q;
    oper_d    = oper_q;
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    mem_ren_d = mem_ren_q;
    mem_wen_d = mem_wen_q;
    if (flush || (en && load_use_stall)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      b_sel_d   = 1'b0;
      oper_d    = EXE_ALU_ADD;
      wb_en_d   = 1'b0;
      wb_addr_d = '0;
      mem_ren_d = 1'b0;
      mem_wen_d = 1'b0;
    end else if (en) begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm_ext;
      b_sel_d   = id_b_sel;
      oper_d    = id_alu_oper;
      wb_en_d   = id_wb_en;
      wb_addr_d = id_wb_addr;
      mem_ren_d = id_mem_ren;
      mem_wen_d = id_mem_wen;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      b_sel_q   <= 1'b0;
      oper_q    <= EXE_ALU_ADD;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      b_sel_q   <= b_sel_d;
      oper_q    <= oper_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
    end
  end

  assign exe_valid    = valid_q;
  assign exe_pc       = pc_q;
  assign exe_alu_a    = rs_fwd;
  assign exe_rt_fwd   = rt_fwd;
  assign exe_alu_b    = b_sel_q ? imm_q : rt_fwd;
  assign exe_alu_oper = oper_q;
  assign exe_wb_en    = wb_en_q;
  assign exe_wb_addr  = wb_addr_q;
  assign exe_mem_ren  = mem_ren_q;
  assign exe_mem_wen  = mem_wen_q;

endmodule
